// File: rtl/ddr2_sched_pkg.sv
// ddr2_sched_pkg: command encoding (cmd_t) and default sizing (NUM_BANK_DEF, BANK_W) shared by the DDR2 bank scheduler
package ddr2_sched_pkg;
  typedef enum logic [2:0] {NOP, ACT, RD, WR, PRE, REF} cmd_t;
  localparam int NUM_BANK_DEF = 4;
  localparam int BANK_W = $clog2(NUM_BANK_DEF);
endpackage

// File: rtl/ddr2_bank_sched_if.sv
// ddr2_bank_sched_if: bank req/gnt handshake, timing inputs and registered DFI command; master=bank side, slave=scheduler
interface ddr2_bank_sched_if #(parameter int NUM_BANK = 4, parameter int T_WIDTH = 4);
  logic [NUM_BANK-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NUM_BANK-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [T_WIDTH-1:0] t_rrd, t_ccd, t_wtr, t_rtw;
  logic cmd_valid;
  ddr2_sched_pkg::cmd_t cmd_type;
  logic [$clog2(NUM_BANK)-1:0] cmd_bank;
  modport master (
    output act_req, rd_req, wr_req, pre_req, ref_req, t_rrd, t_ccd, t_wtr, t_rtw,
    input act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt, cmd_valid, cmd_type, cmd_bank
  );
  modport slave (
    input act_req, rd_req, wr_req, pre_req, ref_req, t_rrd, t_ccd, t_wtr, t_rtw,
    output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt, cmd_valid, cmd_type, cmd_bank
  );
endinterface

// File: rtl/ddr2_rr_arb.sv
// ddr2_rr_arb: combinational round-robin pick starting at ptr (req, ptr -> one-hot gnt, idx, any)
module ddr2_rr_arb #(parameter int N = 4) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int BW = $clog2(N);
  logic [BW-1:0] c;
  logic found;
  assign any = |req;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = ptr + BW'(i);
      if (!found && req[c]) begin
        found = 1'b1;
        gnt[c] = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/ddr2_bank_sched.sv
// ddr2_bank_sched: REF > RD/WR > ACT > PRE round-robin command scheduler with tRRD/tCCD/tWTR/tRTW gaps; ports clk, rst, bus (slave)
module ddr2_bank_sched
  import ddr2_sched_pkg::*;
#(
  parameter int NUM_BANK = NUM_BANK_DEF,
  parameter int T_WIDTH  = 4
) (
  input logic clk,
  input logic rst,
  ddr2_bank_sched_if.slave bus
);
  localparam int BW = $clog2(NUM_BANK);
  logic [T_WIDTH-1:0] rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
  logic [BW-1:0] rr_ptr, rw_idx, act_idx, pre_idx, g_idx;
  logic [NUM_BANK-1:0] rd_e, wr_e, act_e, rw_g, act_g, pre_g;
  logic rw_any, act_any, pre_any;
  cmd_t g_type;
  function automatic logic [T_WIDTH-1:0] nxt(input logic [T_WIDTH-1:0] t, input logic [T_WIDTH-1:0] c, input logic ld);
    return ld ? ((t == '0) ? '0 : t - T_WIDTH'(1)) : ((c == '0) ? '0 : c - T_WIDTH'(1));
  endfunction
  assign rd_e  = bus.rd_req  & {NUM_BANK{ccd_cnt == '0 && wtr_cnt == '0}};
  assign wr_e  = bus.wr_req  & {NUM_BANK{ccd_cnt == '0 && rtw_cnt == '0}};
  assign act_e = bus.act_req & {NUM_BANK{rrd_cnt == '0}};
  ddr2_rr_arb #(.N(NUM_BANK)) u_rw  (.req(rd_e | wr_e),   .ptr(rr_ptr), .gnt(rw_g),  .idx(rw_idx),  .any(rw_any));
  ddr2_rr_arb #(.N(NUM_BANK)) u_act (.req(act_e),         .ptr(rr_ptr), .gnt(act_g), .idx(act_idx), .any(act_any));
  ddr2_rr_arb #(.N(NUM_BANK)) u_pre (.req(bus.pre_req),   .ptr(rr_ptr), .gnt(pre_g), .idx(pre_idx), .any(pre_any));
  always_comb begin
    g_type = rst ? NOP : (&bus.ref_req) ? REF : rw_any ? (rd_e[rw_idx] ? RD : WR) :
             act_any ? ACT : pre_any ? PRE : NOP;
    g_idx  = rw_any ? rw_idx : act_any ? act_idx : pre_idx;
  end
  assign bus.ref_gnt = {NUM_BANK{g_type == REF}};
  assign bus.rd_gnt  = (g_type == RD)  ? rw_g  : '0;
  assign bus.wr_gnt  = (g_type == WR)  ? rw_g  : '0;
  assign bus.act_gnt = (g_type == ACT) ? act_g : '0;
  assign bus.pre_gnt = (g_type == PRE) ? pre_g : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rrd_cnt <= '0;
      ccd_cnt <= '0;
      wtr_cnt <= '0;
      rtw_cnt <= '0;
      rr_ptr <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_type <= NOP;
      bus.cmd_bank <= '0;
    end else begin
      rrd_cnt <= nxt(bus.t_rrd, rrd_cnt, g_type == ACT);
      ccd_cnt <= nxt(bus.t_ccd, ccd_cnt, g_type == RD || g_type == WR);
      wtr_cnt <= nxt(bus.t_wtr, wtr_cnt, g_type == WR);
      rtw_cnt <= nxt(bus.t_rtw, rtw_cnt, g_type == RD);
      if (g_type != NOP && g_type != REF) rr_ptr <= g_idx + BW'(1);
      bus.cmd_valid <= g_type != NOP;
      bus.cmd_type <= g_type;
      bus.cmd_bank <= (g_type == NOP || g_type == REF) ? '0 : g_idx;
    end
  end
endmodule

// File: tb/tb_ddr2_bank_sched.sv
// tb_ddr2_bank_sched: directed and randomized checks of ddr2_bank_sched against a timestamp-based reference model
module tb_ddr2_bank_sched;
  import ddr2_sched_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int l_act = -100, l_rdwr = -100, l_rd = -100, l_wr = -100, ptr = 0;
  cmd_t e_type = NOP, x_type = NOP;
  int e_bank = 0, x_bank = 0;
  bit x_valid = 1'b0;
  logic [N-1:0] e_act, e_rd, e_wr, e_pre, e_ref;
  logic [N-1:0] s_act, s_rd, s_wr, s_pre, s_ref;
  int n;
  ddr2_bank_sched_if #(.NUM_BANK(N), .T_WIDTH(4)) bus ();
  ddr2_bank_sched #(.NUM_BANK(N), .T_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  function automatic bit ok(input int last, input logic [3:0] t);
    return (cyc - last) >= ((t < 4'd2) ? 1 : int'(t));
  endfunction
  task automatic model_comb();
    bit rdok, wrok, actok;
    int b;
    e_type = NOP;
    e_bank = 0;
    rdok  = ok(l_rdwr, bus.t_ccd) && ok(l_wr, bus.t_wtr);
    wrok  = ok(l_rdwr, bus.t_ccd) && ok(l_rd, bus.t_rtw);
    actok = ok(l_act, bus.t_rrd);
    if (!rst && (&bus.ref_req)) e_type = REF;
    for (int cls = 0; cls < 3; cls++)
      for (int k = 0; k < N; k++) begin
        b = (ptr + k) % N;
        if (!rst && e_type == NOP) begin
          if (cls == 0 && bus.rd_req[b] && rdok) e_type = RD;
          else if (cls == 0 && bus.wr_req[b] && wrok) e_type = WR;
          else if (cls == 1 && bus.act_req[b] && actok) e_type = ACT;
          else if (cls == 2 && bus.pre_req[b]) e_type = PRE;
          if (e_type != NOP) e_bank = b;
        end
      end
    e_act = (e_type == ACT) ? N'(1 << e_bank) : '0;
    e_rd  = (e_type == RD)  ? N'(1 << e_bank) : '0;
    e_wr  = (e_type == WR)  ? N'(1 << e_bank) : '0;
    e_pre = (e_type == PRE) ? N'(1 << e_bank) : '0;
    e_ref = (e_type == REF) ? '1 : '0;
  endtask
  task automatic model_seq();
    if (rst) begin
      l_act = -100; l_rdwr = -100; l_rd = -100; l_wr = -100; ptr = 0;
      x_valid = 1'b0; x_type = NOP; x_bank = 0;
    end else begin
      x_valid = e_type != NOP;
      x_type = e_type;
      x_bank = (e_type == NOP || e_type == REF) ? 0 : e_bank;
      case (e_type)
        ACT: begin l_act = cyc; bus.act_req[e_bank] = 1'b0; end
        RD:  begin l_rd = cyc; l_rdwr = cyc; bus.rd_req[e_bank] = 1'b0; end
        WR:  begin l_wr = cyc; l_rdwr = cyc; bus.wr_req[e_bank] = 1'b0; end
        PRE: bus.pre_req[e_bank] = 1'b0;
        REF: bus.ref_req = '0;
        default: ;
      endcase
      if (e_type != NOP && e_type != REF) ptr = (e_bank + 1) % N;
    end
    cyc++;
  endtask
  task automatic step();
    @(negedge clk);
    model_comb();
    s_act = bus.act_gnt; s_rd = bus.rd_gnt; s_wr = bus.wr_gnt; s_pre = bus.pre_gnt; s_ref = bus.ref_gnt;
    chk("act_gnt", s_act, e_act);
    chk("rd_gnt", s_rd, e_rd);
    chk("wr_gnt", s_wr, e_wr);
    chk("pre_gnt", s_pre, e_pre);
    chk("ref_gnt", s_ref, e_ref);
    @(posedge clk);
    #1;
    model_seq();
    chk("cmd_valid", bus.cmd_valid, x_valid);
    chk("cmd_type", bus.cmd_type, x_type);
    chk("cmd_bank", bus.cmd_bank, x_bank);
  endtask
  task automatic clear_reqs();
    bus.act_req = '0; bus.rd_req = '0; bus.wr_req = '0; bus.pre_req = '0; bus.ref_req = '0;
  endtask
  task automatic drain();
    clear_reqs();
    repeat (16) step();
  endtask
  task automatic gen();
    logic [N-1:0] pend;
    pend = bus.act_req | bus.rd_req | bus.wr_req | bus.pre_req;
    for (int b = 0; b < N; b++)
      if (!pend[b] && $urandom_range(0, 3) == 0)
        case ($urandom_range(0, 4))
          0: bus.act_req[b] = 1'b1;
          1: bus.rd_req[b] = 1'b1;
          2: bus.wr_req[b] = 1'b1;
          3: bus.pre_req[b] = 1'b1;
          default: begin bus.rd_req[b] = 1'b1; bus.wr_req[b] = 1'b1; end
        endcase
    bus.ref_req = ($urandom_range(0, 29) == 0) ? '1 : ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
  endtask
  initial begin
    bus.t_rrd = 4'd1; bus.t_ccd = 4'd1; bus.t_wtr = 4'd1; bus.t_rtw = 4'd1;
    bus.act_req = '1; bus.rd_req = '1; bus.wr_req = '1; bus.pre_req = '1; bus.ref_req = '1;
    rst = 1'b1;
    repeat (3) step();
    clear_reqs();
    rst = 1'b0;
    step();
    chk("post_rst_valid", bus.cmd_valid, 1'b0);
    bus.act_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_act", s_act, 32'(1 << i));
    end
    drain();
    bus.t_rrd = 4'd3;
    bus.act_req = 4'b0011;
    bus.pre_req = 4'b0100;
    step(); chk("trrd_b0", s_act, 4'b0001);
    step(); chk("trrd_gap_pre", s_pre, 4'b0100);
    step(); chk("trrd_hold", s_act, 4'b0000);
    step(); chk("trrd_b1", s_act, 4'b0010);
    drain();
    bus.t_wtr = 4'd4; bus.t_ccd = 4'd2; bus.t_rtw = 4'd3;
    bus.wr_req = 4'b0001;
    step(); chk("wtr_wr", s_wr, 4'b0001);
    bus.rd_req = 4'b0010;
    n = 0;
    do begin step(); n++; end while (s_rd == '0 && n < 10);
    chk("wtr_gap", n, 4);
    bus.wr_req = 4'b0010;
    n = 0;
    do begin step(); n++; end while (s_wr == '0 && n < 10);
    chk("rtw_gap", n, 3);
    drain();
    bus.ref_req = 4'b0111;
    step(); chk("ref_partial", s_ref, 4'b0000);
    bus.ref_req = 4'b1111;
    bus.rd_req = 4'b0001;
    step();
    chk("ref_all", s_ref, 4'b1111);
    chk("ref_blocks_rd", s_rd, 4'b0000);
    chk("ref_cmd", bus.cmd_type, REF);
    drain();
    bus.rd_req = 4'b0100; bus.act_req = 4'b0010; bus.pre_req = 4'b1000;
    step(); chk("prio_rd", s_rd, 4'b0100);
    step(); chk("prio_act", s_act, 4'b0010);
    step(); chk("prio_pre", s_pre, 4'b1000);
    for (int seg = 0; seg < 3; seg++) begin
      drain();
      bus.t_rrd = 4'($urandom_range(0, 7));
      bus.t_ccd = 4'($urandom_range(0, 7));
      bus.t_wtr = 4'($urandom_range(0, 7));
      bus.t_rtw = 4'($urandom_range(0, 7));
      for (int it = 0; it < 250; it++) begin
        rst = (seg == 1 && it == 100);
        gen();
        step();
      end
      rst = 1'b0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
